// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_arbiter_if #(
   parameter int unsigned N = 4
) ();
   localparam int unsigned IDX_W = $clog2(N);

   logic             stall;
   logic [N-1:0]     req;
   logic             lock;
   logic [N-1:0]     grant;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;

   modport master (
      output stall,
      output req,
      output lock,
      input  grant,
      input  grant_valid,
      input  grant_idx
   );

   modport slave (
      input  stall,
      input  req,
      input  lock,
      output grant,
      output grant_valid,
      output grant_idx
   );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with stall freeze and zero-latency grant.
// Define ARB_LOCK_EN to build the lock handshake (owner register + LOCKED state).
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input logic         clk,
   input logic         reset,
   rr_arbiter_if.slave arb
);
   localparam int unsigned IDX_W    = $clog2(N);
   localparam int unsigned LAST_IDX = N - 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             scan_hit;
   logic [IDX_W-1:0] scan_idx;
   logic             hold;
   logic [IDX_W-1:0] hold_idx;
   logic             sel_valid;
   logic [IDX_W-1:0] sel_idx;
   logic [N-1:0]     grant_vec;

   // Circular priority scan starting at ptr; wrap handled arithmetically for any N.
   always_comb begin
      int unsigned cand;
      scan_hit = 1'b0;
      scan_idx = '0;
      cand     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!scan_hit && arb.req[IDX_W'(cand)]) begin
            scan_hit = 1'b1;
            scan_idx = IDX_W'(cand);
         end
      end
   end

`ifdef ARB_LOCK_EN
   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;

   assign hold     = (state_q == ST_LOCKED) && arb.req[owner_q];
   assign hold_idx = owner_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_UNLOCKED;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Lock FSM; any stall freezes it.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (!arb.stall) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (sel_valid && arb.lock) begin
                  state_d = ST_LOCKED;
                  owner_d = sel_idx;
               end
            end
            ST_LOCKED: begin
               if (!(arb.req[owner_q] && arb.lock)) begin
                  state_d = ST_UNLOCKED;
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
   end
`else
   logic unused_lock;

   assign unused_lock = arb.lock;
   assign hold        = 1'b0;
   assign hold_idx    = '0;
`endif

   // Final selection; reset masks every output.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      if (!reset) begin
         if (hold) begin
            sel_valid = 1'b1;
            sel_idx   = hold_idx;
         end else if (scan_hit) begin
            sel_valid = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      if (sel_valid) begin
         grant_vec[sel_idx] = 1'b1;
      end
   end

   assign arb.grant       = grant_vec;
   assign arb.grant_valid = sel_valid;
   assign arb.grant_idx   = sel_idx;

   // Priority moves just past whoever was granted, including a held owner.
   always_comb begin
      ptr_d = ptr_q;
      if (!arb.stall && sel_valid) begin
         if (sel_idx == IDX_W'(LAST_IDX)) begin
            ptr_d = '0;
         end else begin
            ptr_d = sel_idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule
